// File: rtl/add16_result_fifo_if.sv
// Producer/consumer handshake bundle for the adder result FIFO.
// The master side drives the write port and the read-ready; the slave side is the FIFO.
interface add16_result_fifo_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic             in_carry;
  logic             in_parity;
  logic             in_overflow;
  logic             in_zero;
  logic             in_sign;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [4:0]       out_flags;

  modport master (
    output in_valid, in_sum, in_carry, in_parity, in_overflow, in_zero, in_sign,
    output out_ready,
    input  in_ready, out_valid, out_sum, out_flags
  );

  modport slave (
    input  in_valid, in_sum, in_carry, in_parity, in_overflow, in_zero, in_sign,
    input  out_ready,
    output in_ready, out_valid, out_sum, out_flags
  );
endinterface

// File: rtl/add16_result_fifo.sv
// Registered result FIFO behind the 16-bit CLA adder, with sticky carry/overflow
// status and a saturating count of accepted results.
module add16_result_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  add16_result_fifo_if.slave     bus,
  input  logic                   sticky_clr,
  output logic [$clog2(DEPTH):0] level,
  output logic                   sticky_carry,
  output logic                   sticky_overflow,
  output logic [CNT_W-1:0]       op_count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [4:0]       flags;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head, head_nxt, in_entry_c;
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic             valid_q, ready_q, valid_nxt, ready_nxt;
  logic             push_c, pop_c;
  logic             sticky_carry_nxt, sticky_overflow_nxt;
  logic [CNT_W-1:0] op_count_nxt;

  assign in_entry_c = '{sum: bus.in_sum,
                         flags: {bus.in_carry, bus.in_parity, bus.in_overflow,
                                 bus.in_zero, bus.in_sign}};
  assign push_c = bus.in_valid & ready_q;
  assign pop_c  = valid_q & bus.out_ready;

  // Next-state for pointers, occupancy, head register and status.
  always_comb begin
    rd_ptr_nxt          = rd_ptr;
    wr_ptr_nxt          = wr_ptr;
    level_nxt           = level;
    head_nxt            = head;
    sticky_carry_nxt    = sticky_carry & ~sticky_clr;
    sticky_overflow_nxt = sticky_overflow & ~sticky_clr;
    op_count_nxt        = op_count;

    if (pop_c)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
    if (push_c) wr_ptr_nxt = wr_ptr + PTR_W'(1);

    case ({push_c, pop_c})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase

    // The new head is either already stored or is the entry being written now.
    if (level_nxt != LVL_W'(0)) begin
      if (push_c && (rd_ptr_nxt == wr_ptr)) head_nxt = in_entry_c;
      else                                  head_nxt = mem[rd_ptr_nxt];
    end

    valid_nxt = (level_nxt != LVL_W'(0));
    ready_nxt = (level_nxt != LVL_W'(DEPTH));

    if (push_c) begin
      sticky_carry_nxt    = sticky_carry_nxt | bus.in_carry;
      sticky_overflow_nxt = sticky_overflow_nxt | bus.in_overflow;
      if (op_count != {CNT_W{1'b1}}) op_count_nxt = op_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      level           <= '0;
      head            <= '0;
      valid_q         <= 1'b0;
      ready_q         <= 1'b1;
      sticky_carry    <= 1'b0;
      sticky_overflow <= 1'b0;
      op_count        <= '0;
    end else begin
      rd_ptr          <= rd_ptr_nxt;
      wr_ptr          <= wr_ptr_nxt;
      level           <= level_nxt;
      head            <= head_nxt;
      valid_q         <= valid_nxt;
      ready_q         <= ready_nxt;
      sticky_carry    <= sticky_carry_nxt;
      sticky_overflow <= sticky_overflow_nxt;
      op_count        <= op_count_nxt;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= in_entry_c;
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.out_sum   = head.sum;
  assign bus.out_flags = head.flags;
endmodule

// File: tb/tb_add16_result_fifo.sv
// Bench for add16_result_fifo: directed scenarios plus random traffic against a
// queue-based reference; a second instance exercises counter saturation.
module tb_add16_result_fifo;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic sticky_clr, sticky_clr2;
  logic [2:0]  level, level2;
  logic        sticky_carry, sticky_overflow, sticky_carry2, sticky_overflow2;
  logic [15:0] op_count;
  logic [3:0]  op_count2;

  int n_checks = 0;
  int n_errors = 0;

  logic [20:0] q[$];
  logic [20:0] hold;
  logic        m_sc, m_so;
  int          m_cnt;

  always #5 clk = ~clk;

  add16_result_fifo_if #(.WIDTH(16)) bus ();
  add16_result_fifo_if #(.WIDTH(16)) bus2 ();

  add16_result_fifo #(.WIDTH(16), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .sticky_clr(sticky_clr), .level(level),
    .sticky_carry(sticky_carry), .sticky_overflow(sticky_overflow), .op_count(op_count)
  );

  add16_result_fifo #(.WIDTH(16), .DEPTH(DEPTH), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .sticky_clr(sticky_clr2), .level(level2),
    .sticky_carry(sticky_carry2), .sticky_overflow(sticky_overflow2), .op_count(op_count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hold  = '0;
    m_sc  = 1'b0;
    m_so  = 1'b0;
    m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    logic [20:0] exp_head;
    exp_head = (q.size() != 0) ? q[0] : hold;
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'(q.size() < DEPTH));
    check({tag, ".level"},     32'(level),         32'(q.size()));
    check({tag, ".out_sum"},   32'(bus.out_sum),   32'(exp_head[20:5]));
    check({tag, ".out_flags"}, 32'(bus.out_flags), 32'(exp_head[4:0]));
    check({tag, ".sticky_c"},  32'(sticky_carry),  32'(m_sc));
    check({tag, ".sticky_o"},  32'(sticky_overflow), 32'(m_so));
    check({tag, ".op_count"},  32'(op_count),      32'(m_cnt));
  endtask

  // Drive one cycle from a negedge, advance the reference at the posedge, check at the next negedge.
  task automatic step(input string tag, input logic iv, input logic [15:0] s,
                      input logic [4:0] f, input logic ordy, input logic clr);
    logic push, pop;
    bus.in_valid = iv;
    bus.in_sum   = s;
    {bus.in_carry, bus.in_parity, bus.in_overflow, bus.in_zero, bus.in_sign} = f;
    bus.out_ready = ordy;
    sticky_clr    = clr;
    push = iv && (q.size() < DEPTH);
    pop  = ordy && (q.size() != 0);
    @(posedge clk);
    if (pop)  hold = q.pop_front();
    if (push) q.push_back({s, f});
    m_sc = (m_sc && !clr) || (push && f[4]);
    m_so = (m_so && !clr) || (push && f[2]);
    if (push && m_cnt != 65535) m_cnt++;
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    sticky_clr = 1'b0; sticky_clr2 = 1'b0;
    bus.in_valid = 1'b0; bus.in_sum = '0; bus.out_ready = 1'b0;
    {bus.in_carry, bus.in_parity, bus.in_overflow, bus.in_zero, bus.in_sign} = 5'b0;
    bus2.in_valid = 1'b0; bus2.in_sum = '0; bus2.out_ready = 1'b0;
    {bus2.in_carry, bus2.in_parity, bus2.in_overflow, bus2.in_zero, bus2.in_sign} = 5'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_all("reset");

    // Single push of 8FFF+8000 result, consumer stalled.
    step("single", 1'b1, 16'h0FFF, 5'b10100, 1'b0, 1'b0);
    // Fill to DEPTH, then a rejected fifth push.
    step("fill1", 1'b1, 16'h0000, 5'b10010, 1'b0, 1'b0);
    step("fill2", 1'b1, 16'hFFFF, 5'b00001, 1'b0, 1'b0);
    step("fill3", 1'b1, 16'h1234, 5'b00000, 1'b0, 1'b0);
    step("full_rej", 1'b1, 16'h5555, 5'b10100, 1'b0, 1'b0);
    step("full_rej_pop", 1'b1, 16'h6666, 5'b00000, 1'b1, 1'b0);
    repeat (5) step("drain", 1'b0, 16'h0, 5'b0, 1'b1, 1'b0);

    // Level 2 then push+pop for 6 cycles across pointer wrap.
    step("lvl2a", 1'b1, 16'hA001, 5'b00011, 1'b0, 1'b0);
    step("lvl2b", 1'b1, 16'hA002, 5'b01000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      step("pushpop", 1'b1, 16'(16'hB000 + i), 5'(i), 1'b1, 1'b0);
    repeat (3) step("drain2", 1'b0, 16'h0, 5'b0, 1'b1, 1'b0);

    // Clear and set in the same cycle: set wins; then clear alone.
    step("clr_set", 1'b1, 16'h7FFF, 5'b00100, 1'b1, 1'b1);
    step("clr_only", 1'b0, 16'h0, 5'b00100, 1'b1, 1'b1);
    step("rej_flags", 1'b0, 16'h0, 5'b10100, 1'b1, 1'b0);

    // Async reset between edges with level 3.
    repeat (3) step("pre_rst", 1'b1, 16'(16'hC000 + $urandom_range(0, 255)), 5'b10100, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b1, 16'hAAAA, 5'b01010, 1'b0, 1'b0);

    // Random traffic against the reference queue.
    for (int i = 0; i < 300; i++) begin
      logic        iv, ordy, clr;
      logic [15:0] s;
      logic [4:0]  f;
      iv   = ($urandom_range(0, 9) < 6);
      ordy = ($urandom_range(0, 9) < 5);
      clr  = ($urandom_range(0, 7) == 0);
      s    = 16'($urandom);
      f    = 5'($urandom);
      step("rand", iv, s, f, ordy, clr);
    end

    // Saturating counter on the CNT_W=4 instance.
    for (int n = 1; n <= 20; n++) begin
      bus2.in_valid  = 1'b1;
      bus2.in_sum    = 16'(n);
      bus2.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("sat_count", 32'(op_count2), 32'((n > 15) ? 15 : n));
    end
    bus2.in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
